button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter_pkg.sv | 25 ++
 rtl/button_event_arbiter_btn_press_classifier.sv | 103 ++++++++++
 rtl/button_event_arbiter.sv | 162 ++++++++++++++++
 tb/tb_button_event_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// button_event_arbiter_pkg
//
// Shared definitions for the button event path: default debounce and
// long-press thresholds (50 MHz clock), the evt_long encoding, and a small
// index helper used by the round-robin pointer.
// -----------------------------------------------------------------------------
package button_event_arbiter_pkg;

    // 20 ms of stable input at 50 MHz before a level change is accepted.
    localparam int unsigned DEFAULT_DB_CYCLES   = 1000000;
    // 5 s of debounced hold at 50 MHz classifies a press as long.
    localparam int unsigned DEFAULT_LONG_CYCLES = 250000000;

    // evt_long encoding.
    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

    // (idx + 1) mod n, for idx in [0, n-1].
    function automatic int unsigned wrap_inc(input int unsigned idx,
                                             input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage : button_event_arbiter_pkg

// File: rtl/button_event_arbiter_btn_press_classifier.sv
// -----------------------------------------------------------------------------
// btn_press_classifier
//
// Per-button front end: 2-flop synchronizer, polarity fix-up, debounce
// counter, hold counter and short/long press classification.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high
//   btn_raw    unsynchronized, bouncing button pin
//   level      debounced pressed level (1 = pressed)
//   short_set  one-cycle pulse: press released before LONG_CYCLES of hold
//   long_set   one-cycle pulse: hold reached LONG_CYCLES while still pressed
//
// Both pulses are registered and appear in the cycle right after the
// debounced edge (or threshold) that qualifies them.
// -----------------------------------------------------------------------------
module btn_press_classifier
    import button_event_arbiter_pkg::*;
#(
    parameter int unsigned DB_CYCLES      = DEFAULT_DB_CYCLES,
    parameter int unsigned LONG_CYCLES    = DEFAULT_LONG_CYCLES,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic short_set,
    output logic long_set
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              sync_q1;
    logic              sync_q2;
    logic              pressed;
    logic              toggle;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    // Synchronizer flops clear to 0. With an active-low pin this reads as
    // "pressed" for the first two cycles after reset; the debounce counter
    // absorbs that as long as DB_CYCLES exceeds the synchronizer depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed = BTN_ACTIVE_LOW ? ~sync_q2 : sync_q2;

    // The level flips on the DB_CYCLES-th consecutive disagreeing cycle.
    assign toggle = (pressed != level) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (pressed == level) begin
            db_cnt <= '0;
        end else if (toggle) begin
            db_cnt <= '0;
            level  <= ~level;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Hold counter restarts on the rising debounced edge and saturates at
    // LONG_CYCLES, so the long pulse fires once per press and the release of
    // a long press (count already at LONG_CYCLES) yields no short pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            short_set <= 1'b0;
            long_set  <= 1'b0;
        end else begin
            short_set <= 1'b0;
            long_set  <= 1'b0;
            if (toggle && !level) begin
                hold_cnt <= '0;
            end else if (toggle && level) begin
                short_set <= (hold_cnt < HOLD_MAX);
            end else if (level && (hold_cnt < HOLD_MAX)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_LAST) begin
                    long_set <= 1'b1;
                end
            end
        end
    end

endmodule : btn_press_classifier

// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//
// Turns NUM_BTN raw, bouncing buttons into a stream of short/long press
// events for a consumer FSM.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high
//   btn_raw       raw button pins (active low when BTN_ACTIVE_LOW=1)
//   btn_level     debounced pressed level per button, 1 = pressed
//   evt_valid     an event is presented
//   evt_ready     consumer accepts the presented event
//   evt_btn       index of the button that produced the event
//   evt_long      EVT_LONG for a long press, EVT_SHORT for a short press
//   evt_overflow  one-cycle pulse when a pending, undelivered event is
//                 overwritten by a new one of the same kind
//
// Handshake: an event transfers on every cycle where evt_valid and evt_ready
// are both high. While evt_valid is high and evt_ready is low, evt_btn and
// evt_long hold. evt_ready is ignored while evt_valid is low. After a
// transfer the next pending event (if any) is presented in the following
// cycle, so a ready consumer can drain one event per cycle.
//
// Each button keeps one short-pending and one long-pending flag. A
// round-robin arbiter picks among buttons with any flag set (long first
// within a button) whenever the output register may be reloaded.
// -----------------------------------------------------------------------------
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int unsigned NUM_BTN        = 4,
    parameter int unsigned DB_CYCLES      = DEFAULT_DB_CYCLES,
    parameter int unsigned LONG_CYCLES    = DEFAULT_LONG_CYCLES,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BTN-1:0]         btn_raw,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_btn,
    output logic                       evt_long,
    output logic                       evt_overflow
);

    localparam int BTN_W = $clog2(NUM_BTN);

    logic [NUM_BTN-1:0] short_set;
    logic [NUM_BTN-1:0] long_set;
    logic [NUM_BTN-1:0] short_pend;
    logic [NUM_BTN-1:0] long_pend;
    logic [NUM_BTN-1:0] pend_req;
    logic [NUM_BTN-1:0] clr_short;
    logic [NUM_BTN-1:0] clr_long;

    logic [BTN_W-1:0]   rr_ptr;
    logic [BTN_W-1:0]   grant_idx;
    logic [BTN_W:0]     cand;
    logic               grant_any;
    logic               grant_long;
    logic               load;
    logic               grant_fire;
    logic               ovf_hit;

    // -------------------------------------------------------------------------
    // Per-button front ends
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTN; g++) begin : gen_btn
        btn_press_classifier #(
            .DB_CYCLES      (DB_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_cls (
            .clk       (clk),
            .reset     (reset),
            .btn_raw   (btn_raw[g]),
            .level     (btn_level[g]),
            .short_set (short_set[g]),
            .long_set  (long_set[g])
        );
    end

    // -------------------------------------------------------------------------
    // Round-robin arbiter
    // -------------------------------------------------------------------------
    assign pend_req = short_pend | long_pend;

    // Offsets are walked from farthest to nearest so that the requester
    // closest to rr_ptr makes the last (winning) assignment.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (BTN_W+1)'(k);
            if (cand >= (BTN_W+1)'(NUM_BTN)) begin
                cand = cand - (BTN_W+1)'(NUM_BTN);
            end
            if (pend_req[cand[BTN_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[BTN_W-1:0];
            end
        end
    end

    assign grant_long = long_pend[grant_idx];
    assign load       = ~evt_valid | evt_ready;
    assign grant_fire = load & grant_any;

    // Only the flag that is actually delivered is consumed; a button with
    // both flags keeps its short flag for a later grant.
    always_comb begin
        clr_short = '0;
        clr_long  = '0;
        if (grant_fire) begin
            if (grant_long) begin
                clr_long[grant_idx] = 1'b1;
            end else begin
                clr_short[grant_idx] = 1'b1;
            end
        end
    end

    // A set landing on a flag that stays set (not consumed this cycle) loses
    // an event. A set landing on a flag that is being granted re-arms it.
    assign ovf_hit = |((short_set & short_pend & ~clr_short) |
                       (long_set  & long_pend  & ~clr_long));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            short_pend   <= '0;
            long_pend    <= '0;
            evt_overflow <= 1'b0;
        end else begin
            short_pend   <= (short_pend & ~clr_short) | short_set;
            long_pend    <= (long_pend  & ~clr_long)  | long_set;
            evt_overflow <= ovf_hit;
        end
    end

    // -------------------------------------------------------------------------
    // Output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_btn   <= '0;
            evt_long  <= EVT_SHORT;
            rr_ptr    <= '0;
        end else if (load) begin
            evt_valid <= grant_any;
            if (grant_any) begin
                evt_btn  <= grant_idx;
                evt_long <= grant_long ? EVT_LONG : EVT_SHORT;
                rr_ptr   <= BTN_W'(wrap_inc(int'(grant_idx), NUM_BTN));
            end
        end
    end

endmodule : button_event_arbiter

// File: tb/tb_button_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_event_arbiter
//
// Bench for button_event_arbiter with DB_CYCLES=4, LONG_CYCLES=20, four
// active-low buttons. Expected events are queued as presses are driven and
// popped by a monitor on every handshake.
// -----------------------------------------------------------------------------
module tb_button_event_arbiter;

    localparam int NUM_BTN = 4;
    localparam int DB      = 4;
    localparam int LONG    = 20;
    localparam int BW      = $clog2(NUM_BTN);
    localparam int W       = BW + 1;

    typedef struct {
        int   btn;
        int   hold;
        logic has_evt;
        logic lng;
    } vec_t;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_BTN-1:0] btn_raw = '1;
    logic [NUM_BTN-1:0] btn_level;
    logic               evt_valid;
    logic               evt_ready = 1'b1;
    logic [BW-1:0]      evt_btn;
    logic               evt_long;
    logic               evt_overflow;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .NUM_BTN        (NUM_BTN),
        .DB_CYCLES      (DB),
        .LONG_CYCLES    (LONG),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_btn      (evt_btn),
        .evt_long     (evt_long),
        .evt_overflow (evt_overflow)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           ovf_cnt  = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: compare each handshake against the head of the queue.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got btn=%0d long=%0b, expected none (t=%0t)",
                         evt_btn, evt_long, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event_btn_long", {29'd0, evt_btn, evt_long}, {29'd0, mon_exp});
            end
        end
        if (!reset && evt_overflow) ovf_cnt++;
    end

    // -------------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge)
    // -------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int b, input int hold);
        btn_raw[b] = 1'b0;
        tick(hold);
        btn_raw[b] = 1'b1;
    endtask

    task automatic expect_evt(input int b, input logic lng);
        exp_q.push_back({BW'(b), lng});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || evt_valid) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (!evt_valid && n < budget) begin
            tick(1);
            n++;
        end
        check(name, evt_valid, 1);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        vec_t vecs[8];
        int   n;

        // Press durations in raw cycles: <4 is rejected as bounce, up to 20
        // is short, 21 and more is long.
        vecs[0] = '{btn: 0, hold: 10, has_evt: 1'b1, lng: 1'b0};
        vecs[1] = '{btn: 1, hold: 4,  has_evt: 1'b1, lng: 1'b0};
        vecs[2] = '{btn: 2, hold: 3,  has_evt: 1'b0, lng: 1'b0};
        vecs[3] = '{btn: 3, hold: 20, has_evt: 1'b1, lng: 1'b0};
        vecs[4] = '{btn: 0, hold: 21, has_evt: 1'b1, lng: 1'b1};
        vecs[5] = '{btn: 1, hold: 40, has_evt: 1'b1, lng: 1'b1};
        vecs[6] = '{btn: 2, hold: int'($urandom_range(5, 15)),  has_evt: 1'b1, lng: 1'b0};
        vecs[7] = '{btn: 3, hold: int'($urandom_range(24, 30)), has_evt: 1'b1, lng: 1'b1};

        // Reset state
        tick(3);
        check("rst_btn_level", btn_level, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_btn", evt_btn, 0);
        check("rst_evt_long", evt_long, 0);
        check("rst_evt_overflow", evt_overflow, 0);
        reset = 1'b0;
        tick(10);
        check("idle_no_level", btn_level, 0);

        // Table-driven presses with the consumer always ready
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].has_evt) expect_evt(vecs[i].btn, vecs[i].lng);
            press(vecs[i].btn, vecs[i].hold);
            tick(30);
            wait_idle("vec_drain", 100);
        end
        check("no_overflow_in_table", ovf_cnt, 0);

        // Bounce filtering: 3-cycle glitch, then a real 10-cycle press
        btn_raw[1] = 1'b0;
        tick(3);
        btn_raw[1] = 1'b1;
        tick(10);
        check("glitch_no_level", btn_level, 0);
        expect_evt(1, 1'b0);
        press(1, 10);
        tick(30);
        wait_idle("bounce_drain", 100);

        // Long press: event must be delivered while the button is still held
        expect_evt(2, 1'b1);
        btn_raw[2] = 1'b0;
        tick(40);
        check("long_while_held", exp_q.size(), 0);
        check("long_level_held", btn_level[2], 1);
        btn_raw[2] = 1'b1;
        tick(30);
        wait_idle("long_release_drain", 100);

        // Backpressure fairness. A button-3 event first leaves rr_ptr at 0.
        expect_evt(3, 1'b0);
        press(3, 6);
        tick(30);
        wait_idle("rr_prep_drain", 100);

        evt_ready = 1'b0;
        expect_evt(0, 1'b0);
        expect_evt(3, 1'b0);
        btn_raw[0] = 1'b0;
        btn_raw[3] = 1'b0;
        tick(10);
        btn_raw[0] = 1'b1;
        btn_raw[3] = 1'b1;
        wait_valid("bp_valid", 50, n);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_valid_held", evt_valid, 1);
            check("bp_btn_stable", evt_btn, 0);
            check("bp_long_stable", evt_long, 0);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        check("bp_first_btn0", {evt_valid, evt_btn}, {1'b1, 2'd0});
        @(negedge clk);
        check("bp_second_btn3", {evt_valid, evt_btn}, {1'b1, 2'd3});
        @(posedge clk);
        #1;
        wait_idle("bp_drain", 50);

        // Next simultaneous pair: rr_ptr wrapped to 0, so 0 goes first again
        expect_evt(0, 1'b0);
        expect_evt(3, 1'b0);
        btn_raw[0] = 1'b0;
        btn_raw[3] = 1'b0;
        tick(10);
        btn_raw[0] = 1'b1;
        btn_raw[3] = 1'b1;
        tick(30);
        wait_idle("pair_wrap_drain", 100);

        // Overflow: button 1 pressed twice while button 0's event is stalled
        ovf_cnt   = 0;
        evt_ready = 1'b0;
        expect_evt(0, 1'b0);
        expect_evt(1, 1'b0);
        press(0, 8);
        tick(12);
        press(1, 8);
        tick(12);
        press(1, 8);
        tick(20);
        check("ovf_pulses", ovf_cnt, 1);
        check("ovf_stalled_btn", {evt_valid, evt_btn}, {1'b1, 2'd0});
        evt_ready = 1'b1;
        tick(5);
        wait_idle("ovf_drain", 50);
        check("ovf_total", ovf_cnt, 1);

        // Reset mid-operation: event stalled, button 2 at hold count 10
        evt_ready = 1'b0;
        expect_evt(3, 1'b0);
        press(3, 6);
        tick(20);
        check("rst_mid_evt_pending", evt_valid, 1);
        btn_raw[2] = 1'b0;
        tick(16);
        check("rst_mid_level_before", btn_level[2], 1);
        reset = 1'b1;
        #1;
        check("rst_mid_btn_level", btn_level, 0);
        check("rst_mid_evt_valid", evt_valid, 0);
        check("rst_mid_evt_btn", evt_btn, 0);
        check("rst_mid_evt_long", evt_long, 0);
        check("rst_mid_evt_overflow", evt_overflow, 0);
        exp_q.delete();
        tick(3);
        reset     = 1'b0;
        evt_ready = 1'b1;
        expect_evt(2, 1'b1);
        wait_valid("rst_long_arrives", 60, n);
        check("rst_long_latency", (n >= 24 && n <= 30), 1);
        tick(5);
        btn_raw[2] = 1'b1;
        tick(30);
        wait_idle("rst_release_drain", 100);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_button_event_arbiter
